// File: rtl/key_uart_tx_if.sv
// key_uart_tx_if: event/serial bundle between a paddle-key source and the
// key-event UART transmitter.
//   ev[3:0]  one-cycle key strobes, bit0=I bit1=K bit2=W bit3=S (source -> tx)
//   upper    case select sampled when a frame is loaded          (source -> tx)
//   tx       UART serial line, idle high                         (tx -> source)
//   busy     frame in progress                                   (tx -> source)
//   sent     pulse on the last cycle of a stop bit               (tx -> source)
//   dropped  pulse when a strobe hits an already pending key     (tx -> source)
interface key_uart_tx_if;
    logic [3:0] ev;
    logic       upper;
    logic       tx;
    logic       busy;
    logic       sent;
    logic       dropped;

    modport master (
        output ev,
        output upper,
        input  tx,
        input  busy,
        input  sent,
        input  dropped
    );

    modport slave (
        input  ev,
        input  upper,
        output tx,
        output busy,
        output sent,
        output dropped
    );
endinterface

// File: rtl/key_uart_tx.sv
// key_uart_tx: turns paddle-key event strobes (I, K, W, S) into ASCII
// characters and sends each one as an 8N1 UART frame.
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   key_uart_tx_if slave modport: ev, upper in; tx, busy, sent, dropped out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for a pending key; loads one when present
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); sent pulses on its final cycle
module key_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic          clk,
    input  logic          rst,
    key_uart_tx_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    // Uppercase codes; lowercase differs only in bit 5.
    localparam logic [7:0] CHAR_I = 8'h49;
    localparam logic [7:0] CHAR_K = 8'h4B;
    localparam logic [7:0] CHAR_W = 8'h57;
    localparam logic [7:0] CHAR_S = 8'h53;
    localparam logic [7:0] CASE_BIT = 8'h20;

    logic [1:0]  state, state_n;
    logic [15:0] bit_cnt, bit_cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic [3:0]  pend;
    logic [3:0]  pick_mask;
    logic [3:0]  load_mask;
    logic [7:0]  pick_char;
    logic [7:0]  load_byte;
    logic        load;
    logic        bit_done;
    logic        tx_r, tx_n;
    logic        dropped_r;

    // Lowest pending index wins: I > K > W > S.
    always_comb begin
        pick_mask = 4'b0000;
        pick_char = 8'h00;
        if (pend[0]) begin
            pick_mask = 4'b0001;
            pick_char = CHAR_I;
        end else if (pend[1]) begin
            pick_mask = 4'b0010;
            pick_char = CHAR_K;
        end else if (pend[2]) begin
            pick_mask = 4'b0100;
            pick_char = CHAR_W;
        end else if (pend[3]) begin
            pick_mask = 4'b1000;
            pick_char = CHAR_S;
        end
    end

    assign load      = (state == S_IDLE) && (pend != 4'b0000);
    assign load_mask = load ? pick_mask : 4'b0000;
    assign load_byte = bus.upper ? pick_char : (pick_char | CASE_BIT);
    assign bit_done  = (bit_cnt == BIT_LAST);

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        idx_n     = idx;
        shift_n   = shift;
        case (state)
            S_IDLE: begin
                if (load) begin
                    state_n   = S_START;
                    bit_cnt_n = 16'd0;
                    shift_n   = load_byte;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_n   = S_DATA;
                    bit_cnt_n = 16'd0;
                    idx_n     = 3'd0;
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_cnt_n = 16'd0;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                        idx_n   = 3'd0;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_n   = S_IDLE;
                    bit_cnt_n = 16'd0;
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            default: begin
                state_n   = S_IDLE;
                bit_cnt_n = 16'd0;
                idx_n     = 3'd0;
            end
        endcase
    end

    // tx is registered from the next-state view so the line never glitches
    // and still falls right after the load edge.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= 16'd0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            pend      <= 4'b0000;
            tx_r      <= 1'b1;
            dropped_r <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            // Set beats clear: a strobe on the key being loaded re-arms it.
            pend      <= (pend & ~load_mask) | bus.ev;
            tx_r      <= tx_n;
            // Any number of colliding keys yields a single pulse.
            dropped_r <= |(bus.ev & pend & ~load_mask);
        end
    end

    assign bus.tx      = tx_r;
    assign bus.busy    = (state != S_IDLE);
    assign bus.sent    = (state == S_STOP) && bit_done;
    assign bus.dropped = dropped_r;

endmodule
